led_cmd_tx: RTL and testbench
=============================

# led_cmd_tx

Host-side serializer for the LED controller's 3-wire command link (serial clock, data, latch). It accepts one LED command per valid/ready handshake: a 5-bit LED address and a 2-bit LED state. It emits the command as an 8-bit frame, MSB first, framed by the latch line, and does so at a programmable serial rate derived from the system clock. It sits in the driving FPGA/MCU-bridge logic and feeds the CPLD's shift-register receiver directly.

## Interface
Parameters:
- DIV, 4: serial half-period in CLK cycles; legal values are 1 to 255.
- NUM_LEDS, 21: number of addressable LEDs; legal addresses are 0 to NUM_LEDS-1.

Ports:
- CLK, input, 1: system clock; all logic runs on the rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- CMD_VALID, input, 1: a command is presented.
- CMD_READY, output, 1: the block can accept a command.
- CMD_ADDR, input, 5: target LED address.
- CMD_STATE, input, 2: LED state (00 off, 01 on, 10 pattern1, 11 pattern2).
- CMD_ERR, output, 1: one-cycle pulse when a command with an illegal address is dropped.
- SCLK, output, 1: serial clock to the receiver.
- SDATA, output, 1: serial data, MSB first.
- SLATCH, output, 1: frame enable; high for the whole frame.
- BUSY, output, 1: high while a frame is in progress.

## Operation
- Frame format: frame[7] = 0 (reserved), frame[6:5] = CMD_STATE, frame[4:0] = CMD_ADDR.
- A handshake occurs on a rising CLK edge where CMD_VALID && CMD_READY. The block captures CMD_ADDR and CMD_STATE at that edge.
- If CMD_ADDR >= NUM_LEDS:
  - no frame is sent;
  - CMD_ERR is high for exactly the next cycle;
  - CMD_READY stays high.
- FSM states are IDLE, SETUP, HIGH, LOW, HOLD and GAP.
  - IDLE: CMD_READY = 1. A legal handshake moves to SETUP.
  - SETUP: SLATCH = 1, SCLK = 0, SDATA = frame[7]. Lasts DIV cycles, then goes to HIGH.
  - HIGH: SCLK = 1, SDATA is held. Lasts DIV cycles. If fewer than 8 bits have been sent, go to LOW; after the 8th bit, go to HOLD.
  - LOW: SCLK = 0, SDATA = next bit. Lasts DIV cycles, then goes to HIGH.
  - HOLD: SCLK = 0, SLATCH = 1, SDATA holds frame[0]. Lasts DIV cycles, then goes to GAP.
  - GAP: SLATCH = 0, SDATA = 0. Lasts DIV cycles, then goes to IDLE.
- SDATA only changes while SCLK is low. The receiver samples on the SCLK rising edge.
- Counters:
  - The half-period counter is 8 bits and counts 0 to DIV-1.
  - The bit counter is 3 bits.
  - Both clear on handshake; neither wraps mid-frame.
- CMD_VALID, CMD_ADDR and CMD_STATE are ignored while CMD_READY = 0.

## Timing
- All outputs are registered. Reset values are CMD_READY = 0, CMD_ERR = 0, SCLK = 0, SDATA = 0, SLATCH = 0 and BUSY = 0.
- CMD_READY rises on the first CLK edge after RST_N deasserts.
- For a legal handshake at edge t0:
  - SLATCH, BUSY and SETUP take effect at t0+1; CMD_READY falls at t0+1.
  - SLATCH is high for exactly 17*DIV cycles: SETUP DIV, 8 HIGH phases of DIV each, 7 LOW phases of DIV each, HOLD DIV.
  - GAP lasts DIV cycles.
  - CMD_READY and IDLE return at t0+1+18*DIV; BUSY falls at the same edge.
- Back-to-back commands: if CMD_VALID is held high, the next handshake occurs on the first IDLE cycle. The minimum command spacing is therefore 18*DIV+1 cycles.
- SCLK rising edges for bit k (k = 0 for the MSB) occur at t0+1+(2k+1)*DIV.
- An illegal address and the following valid command may handshake on consecutive cycles.
- Reset mid-frame: all outputs go to their reset values immediately (asynchronously). The partial frame is abandoned. SLATCH falling before 8 clocks is defined as a receiver-discarded frame.

## Structure
- Package led_link_pkg holds:
  - FRAME_W = 8, ADDR_W = 5 and STATE_W = 2;
  - the LED state encodings LED_OFF, LED_ON, LED_PAT1 and LED_PAT2;
  - the FSM state enum.
- The package is shared with the receiver-side top.
- One sub-module, led_link_tick, is the half-period counter. It outputs a one-cycle tick every DIV cycles and is restarted by the FSM on each state entry.

## Test plan
- Reset release: CMD_READY = 0 during reset and 1 one cycle after RST_N rises; SCLK, SDATA and SLATCH are 0.
- DIV = 4, command addr 5, state 01:
  - SDATA is sampled as 0,0,1,0,0,1,0,1 on the 8 SCLK rises, at t0+5, t0+13, … t0+61;
  - SLATCH is high for 68 cycles;
  - CMD_READY returns at t0+73.
- Illegal address 21 followed by legal address 20, state 11:
  - CMD_ERR pulses once and no SLATCH activity occurs for address 21;
  - frame 0x74 follows, handshaking on the next cycle.
- CMD_VALID held high with two commands (addr 0 state 10, then addr 16 state 11):
  - frames are 0x40 and 0x70;
  - the second handshake occurs exactly 18*DIV+1 cycles after the first.
- DIV = 1, addr 31: handled as an illegal address (NUM_LEDS = 21). Then addr 0 state 00: frame 0x00, SLATCH high for 17 cycles.
- RST_N asserted mid-frame, after the 3rd SCLK rise: SCLK, SLATCH and BUSY go low asynchronously; after release, a new command is transmitted correctly.

Source files
------------

// File: rtl/led_link_pkg.sv
// Shared definitions for the LED command link.
// Both the host-side serializer and the receiver-side top import this package.
package led_link_pkg;

    localparam int FRAME_W = 8;
    localparam int ADDR_W  = 5;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        LED_OFF  = 2'b00,
        LED_ON   = 2'b01,
        LED_PAT1 = 2'b10,
        LED_PAT2 = 2'b11
    } led_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } link_state_e;

    // The frame's MSB is reserved and is always sent as 0.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [STATE_W-1:0] led_state,
        input logic [ADDR_W-1:0]  led_addr
    );
        return {1'b0, led_state, led_addr};
    endfunction

endpackage

// File: rtl/led_link_tick.sv
// Half-period timer for the serial link.
// While restart is high the count is held at zero; otherwise it ticks once every DIV cycles.
module led_link_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_cmd_tx.sv
// Host-side serializer for the 3-wire LED command link (SCLK, SDATA, SLATCH).
// Accepts one command per handshake and shifts out an 8-bit frame, MSB first.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a command; illegal addresses pulse CMD_ERR
// ST_SETUP | latch raised, SCLK low, SDATA carries frame[7]
// ST_HIGH  | SCLK high, receiver samples SDATA
// ST_LOW   | SCLK low, SDATA carries the next bit
// ST_HOLD  | SCLK low, latch still high, SDATA holds frame[0]
// ST_GAP   | latch low, SDATA low, inter-frame spacing
module led_cmd_tx
    import led_link_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int NUM_LEDS = 21
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [ADDR_W-1:0]  CMD_ADDR,
    input  logic [STATE_W-1:0] CMD_STATE,
    output logic               CMD_ERR,
    output logic               SCLK,
    output logic               SDATA,
    output logic               SLATCH,
    output logic               BUSY
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_LEDS);

    link_state_e        state;
    logic [FRAME_W-2:0] shreg;
    logic [2:0]         bit_cnt;
    logic [FRAME_W-1:0] frame_in;
    logic               tick;
    logic               handshake;
    logic               addr_ok;

    assign handshake = CMD_VALID && CMD_READY;
    assign addr_ok   = ({1'b0, CMD_ADDR} < ADDR_LIMIT);
    assign frame_in  = build_frame(CMD_STATE, CMD_ADDR);

    // Holding the timer in IDLE makes every phase start from a zero count.
    led_link_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (CLK),
        .rst_n   (RST_N),
        .restart (state == ST_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            CMD_READY <= 1'b0;
            CMD_ERR   <= 1'b0;
            SCLK      <= 1'b0;
            SDATA     <= 1'b0;
            SLATCH    <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            CMD_ERR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    CMD_READY <= 1'b1;
                    if (handshake) begin
                        bit_cnt <= '0;
                        if (addr_ok) begin
                            state     <= ST_SETUP;
                            shreg     <= frame_in[FRAME_W-2:0];
                            SDATA     <= frame_in[FRAME_W-1];
                            SCLK      <= 1'b0;
                            SLATCH    <= 1'b1;
                            BUSY      <= 1'b1;
                            CMD_READY <= 1'b0;
                        end else begin
                            CMD_ERR <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state <= ST_HIGH;
                        SCLK  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        SCLK <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_HOLD;
                        end else begin
                            state   <= ST_LOW;
                            bit_cnt <= bit_cnt + 3'd1;
                            SDATA   <= shreg[FRAME_W-2];
                            shreg   <= {shreg[FRAME_W-3:0], 1'b0};
                        end
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        state <= ST_HIGH;
                        SCLK  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state  <= ST_GAP;
                        SLATCH <= 1'b0;
                        SDATA  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state     <= ST_IDLE;
                        BUSY      <= 1'b0;
                        CMD_READY <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_cmd_tx.sv
// Directed bench for led_cmd_tx: one instance at DIV=4, one at DIV=1.
// Outputs are sampled on the falling clock edge; expected frames are hand-computed.
module tb_led_cmd_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sel   = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       v4 = 1'b0, v1 = 1'b0;
    logic [4:0] a4 = '0, a1 = '0;
    logic [1:0] s4 = '0, s1 = '0;
    logic r4, e4, sc4, sd4, sl4, b4;
    logic r1, e1, sc1, sd1, sl1, b1;

    led_cmd_tx #(.DIV(4), .NUM_LEDS(21)) u_div4 (
        .CLK(clk), .RST_N(rst_n), .CMD_VALID(v4), .CMD_READY(r4),
        .CMD_ADDR(a4), .CMD_STATE(s4), .CMD_ERR(e4), .SCLK(sc4),
        .SDATA(sd4), .SLATCH(sl4), .BUSY(b4)
    );

    led_cmd_tx #(.DIV(1), .NUM_LEDS(21)) u_div1 (
        .CLK(clk), .RST_N(rst_n), .CMD_VALID(v1), .CMD_READY(r1),
        .CMD_ADDR(a1), .CMD_STATE(s1), .CMD_ERR(e1), .SCLK(sc1),
        .SDATA(sd1), .SLATCH(sl1), .BUSY(b1)
    );

    logic m_ready, m_err, m_sclk, m_sdata, m_slatch, m_busy;
    assign m_ready  = sel ? r1  : r4;
    assign m_err    = sel ? e1  : e4;
    assign m_sclk   = sel ? sc1 : sc4;
    assign m_sdata  = sel ? sd1 : sd4;
    assign m_slatch = sel ? sl1 : sl4;
    assign m_busy   = sel ? b1  : b4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [1:0] s);
        if (sel) begin
            v1 = v; a1 = a; s1 = s;
        end else begin
            v4 = v; a4 = a; s4 = s;
        end
    endtask

    // Call on a falling edge; returns just after the handshake edge.
    task automatic handshake(input logic [4:0] a, input logic [1:0] s, input string tag,
                             output int t0);
        int n;
        n = 0;
        drive(1'b1, a, s);
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_hs_ready"}, m_ready, 1);
        @(posedge clk);
        #1 t0 = cyc;
    endtask

    // Sample index j = 0 is the first falling edge after the handshake edge.
    task automatic check_frame(input string tag, input int div, input logic [7:0] exp);
        logic [7:0] bits;
        logic       prev;
        int rises, latch_cnt, first_rise, last_rise, ready_at, errs;
        bits = '0; prev = 1'b0; rises = 0; latch_cnt = 0;
        first_rise = -1; last_rise = -1; ready_at = -1; errs = 0;
        for (int j = 0; j < 18 * div + 8; j++) begin
            @(negedge clk);
            if (m_sclk && !prev) begin
                bits = {bits[6:0], m_sdata};
                if (rises == 0) first_rise = j;
                last_rise = j;
                rises++;
            end
            prev = m_sclk;
            if (m_slatch) latch_cnt++;
            if (m_err) errs++;
            if (m_ready) begin
                ready_at = j;
                break;
            end
        end
        chk({tag, "_frame"},      bits,       exp);
        chk({tag, "_rises"},      rises,      8);
        chk({tag, "_latch_len"},  latch_cnt,  17 * div);
        chk({tag, "_first_rise"}, first_rise, div);
        chk({tag, "_last_rise"},  last_rise,  15 * div);
        chk({tag, "_ready_ret"},  ready_at,   18 * div);
        chk({tag, "_no_err"},     errs,       0);
        chk({tag, "_idle_busy"},  m_busy,     0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, n;
        logic prev;

        // reset state and release
        repeat (3) @(negedge clk);
        chk("rst_ready",  m_ready,  0);
        chk("rst_sclk",   m_sclk,   0);
        chk("rst_sdata",  m_sdata,  0);
        chk("rst_slatch", m_slatch, 0);
        chk("rst_busy",   m_busy,   0);
        rst_n = 1'b1;
        chk("rel_ready_before_edge", m_ready, 0);
        @(negedge clk);
        chk("rel_ready_after_edge", m_ready, 1);

        // addr 5, state 01 -> 0x25
        handshake(5'd5, 2'b01, "c1", t0);
        drive(1'b0, '0, '0);
        check_frame("c1", 4, 8'h25);

        // illegal 21 then legal 20/11 on the next cycle -> 0x74
        handshake(5'd21, 2'b11, "ill", t0);
        drive(1'b1, 5'd20, 2'b11);
        @(negedge clk);
        chk("ill_err",    m_err,    1);
        chk("ill_ready",  m_ready,  1);
        chk("ill_slatch", m_slatch, 0);
        chk("ill_busy",   m_busy,   0);
        @(posedge clk);
        #1 t1 = cyc;
        drive(1'b0, '0, '0);
        chk("ill_next_hs", t1 - t0, 1);
        check_frame("l20", 4, 8'h74);

        // back-to-back with CMD_VALID held: 0x40 then 0x70
        handshake(5'd0, 2'b10, "b2b1", t0);
        check_frame("b2b1", 4, 8'h40);
        drive(1'b1, 5'd16, 2'b11);
        @(posedge clk);
        #1 t1 = cyc;
        drive(1'b0, '0, '0);
        chk("b2b_spacing", t1 - t0, 18 * 4 + 1);
        check_frame("b2b2", 4, 8'h70);

        // DIV = 1: addr 31 illegal, then addr 0 state 00
        sel = 1'b1;
        handshake(5'd31, 2'b00, "d1ill", t0);
        drive(1'b1, 5'd0, 2'b00);
        @(negedge clk);
        chk("d1ill_err",    m_err,    1);
        chk("d1ill_slatch", m_slatch, 0);
        @(posedge clk);
        #1 t1 = cyc;
        drive(1'b0, '0, '0);
        chk("d1_next_hs", t1 - t0, 1);
        check_frame("d1", 1, 8'h00);

        // reset after the third SCLK rise, then a clean frame
        sel = 1'b0;
        @(negedge clk);
        handshake(5'd5, 2'b01, "rst", t0);
        drive(1'b0, '0, '0);
        n = 0; prev = 1'b0;
        for (int j = 0; j < 100 && n < 3; j++) begin
            @(negedge clk);
            if (m_sclk && !prev) n++;
            prev = m_sclk;
        end
        chk("mid_rises",      n,        3);
        chk("mid_sclk_pre",   m_sclk,   1);
        chk("mid_slatch_pre", m_slatch, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_sclk",   m_sclk,   0);
        chk("mid_slatch", m_slatch, 0);
        chk("mid_busy",   m_busy,   0);
        chk("mid_ready",  m_ready,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_ready", m_ready, 1);
        handshake(5'd20, 2'b10, "post", t0);
        drive(1'b0, '0, '0);
        check_frame("post", 4, 8'h54);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
